// File: rtl/synth_audio_pkg.sv
// rtl/synth_audio_pkg.sv - shared constants and sample conversion for the synth audio output path
package synth_audio_pkg;

  localparam int SAMPLE_W   = 11;
  localparam int SLOT_W     = 16;
  localparam int FRAME_BITS = 64;

  // Offset-binary sample to signed slot: flip the MSB, then left-justify in the slot
  function automatic logic [SLOT_W-1:0] to_slot(input logic [SAMPLE_W-1:0] s);
    return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0], {(SLOT_W-SAMPLE_W){1'b0}}};
  endfunction

endpackage

// File: rtl/bclk_gen.sv
// rtl/bclk_gen.sv - bit clock divider producing a registered bclk and its falling-edge strobe
module bclk_gen #(
  parameter int BCLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  output logic bclk,
  output logic fall_en
);

  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DW-1:0] divcnt;
  logic          tc;

  assign tc      = (divcnt == DW'(BCLK_DIV - 1));
  // Strobe marks the clk edge on which bclk goes 1->0; downstream serial state moves on it
  assign fall_en = ena && tc && bclk;

  // Half-period counter; bclk toggles at terminal count, ena low parks everything at reset state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divcnt <= '0;
      bclk   <= 1'b0;
    end else if (!ena) begin
      divcnt <= '0;
      bclk   <= 1'b0;
    end else if (tc) begin
      divcnt <= '0;
      bclk   <= ~bclk;
    end else begin
      divcnt <= divcnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - Philips I2S transmitter with one-deep sample holding register
module i2s_tx
  import synth_audio_pkg::*;
#(
  parameter int BCLK_DIV = 2,
  parameter int SAMPLE_W = synth_audio_pkg::SAMPLE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [SAMPLE_W-1:0] sample_l,
  input  logic [SAMPLE_W-1:0] sample_r,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                underrun,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata
);

  localparam logic [SAMPLE_W-1:0] MIDSCALE = {1'b1, {(SAMPLE_W-1){1'b0}}};

  logic                  fall_en;
  logic [5:0]            bitcnt;
  logic [5:0]            bitcnt_next;
  logic [FRAME_BITS-1:0] shreg;
  logic                  load_edge;
  logic                  pend_full;
  logic [SAMPLE_W-1:0]   pend_l, pend_r;
  logic [SAMPLE_W-1:0]   last_l, last_r;
  logic [SAMPLE_W-1:0]   frame_l, frame_r;
  logic [FRAME_BITS-1:0] frame;

  bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .bclk    (bclk),
    .fall_en (fall_en)
  );

  assign bitcnt_next  = bitcnt + 6'd1;
  // Loading at bitcnt 1 places each slot MSB one bclk after the lrclk transition
  assign load_edge    = fall_en && (bitcnt_next == 6'd1);
  assign sample_ready = !pend_full;
  assign sdata        = shreg[FRAME_BITS-1];

  // Pick the pair for the next frame: queued pair, else same-cycle bypass, else repeat last
  always_comb begin
    frame_l = last_l;
    frame_r = last_r;
    if (pend_full) begin
      frame_l = pend_l;
      frame_r = pend_r;
    end else if (sample_valid) begin
      frame_l = sample_l;
      frame_r = sample_r;
    end
  end

  assign frame = {to_slot(frame_l), {SLOT_W{1'b0}}, to_slot(frame_r), {SLOT_W{1'b0}}};

  // Bit counter, word select and frame shifter all advance on bclk falling edges only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitcnt <= '0;
      lrclk  <= 1'b0;
      shreg  <= '0;
    end else if (!ena) begin
      bitcnt <= '0;
      lrclk  <= 1'b0;
      shreg  <= '0;
    end else if (fall_en) begin
      bitcnt <= bitcnt_next;
      lrclk  <= bitcnt_next[5];
      if (bitcnt_next == 6'd1) shreg <= frame;
      else                     shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
    end
  end

  // Holding register: capture when empty, drain at the frame load, flag frames with no new pair
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_full <= 1'b0;
      pend_l    <= MIDSCALE;
      pend_r    <= MIDSCALE;
      last_l    <= MIDSCALE;
      last_r    <= MIDSCALE;
      underrun  <= 1'b0;
    end else if (!ena) begin
      pend_full <= 1'b0;
      pend_l    <= MIDSCALE;
      pend_r    <= MIDSCALE;
      last_l    <= MIDSCALE;
      last_r    <= MIDSCALE;
      underrun  <= 1'b0;
    end else begin
      underrun <= load_edge && !pend_full && !sample_valid;
      if (load_edge) begin
        pend_full <= 1'b0;
        last_l    <= frame_l;
        last_r    <= frame_r;
      end else if (sample_valid && !pend_full) begin
        pend_full <= 1'b1;
        pend_l    <= sample_l;
        pend_r    <= sample_r;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// tb/tb_i2s_tx.sv - randomized self-checking bench for i2s_tx against a frame-level model
module tb_i2s_tx;

  localparam int DIV  = 2;
  localparam int FCLK = 128 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ena = 1'b0;
  logic [10:0] sample_l = 11'h0;
  logic [10:0] sample_r = 11'h0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        underrun;
  logic        bclk;
  logic        lrclk;
  logic        sdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2s_tx #(.BCLK_DIV(DIV), .SAMPLE_W(11)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .underrun     (underrun),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: clk edges since enable, accepted pairs, and the frame currently on the wire
  int          n = 0;
  bit          pend_m = 0;
  logic [10:0] pl = 11'h400, pr = 11'h400;
  logic [10:0] ll = 11'h400, lr = 11'h400;
  logic [63:0] frame_m = 64'h0;
  bit          und_m = 0;
  bit          acc_m = 0;

  function automatic logic [15:0] slot_of(input logic [10:0] s);
    return 16'((int'(s) - 1024) * 32);
  endfunction

  function automatic logic [63:0] frame_of(input logic [10:0] l, input logic [10:0] r);
    return {slot_of(l), 16'h0, slot_of(r), 16'h0};
  endfunction

  function automatic int bitpos(input int edges);
    return (edges / (2 * DIV)) % 64;
  endfunction

  function automatic bit is_load(input int edges);
    return (edges % (2 * DIV) == 0) && (bitpos(edges) == 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || !ena) begin
      n = 0; pend_m = 0; ll = 11'h400; lr = 11'h400;
      frame_m = 64'h0; und_m = 0; acc_m = 0;
    end else begin
      n++;
      und_m = 0;
      acc_m = 0;
      if (is_load(n)) begin
        if (pend_m) begin
          frame_m = frame_of(pl, pr); ll = pl; lr = pr; pend_m = 0;
        end else if (sample_valid) begin
          frame_m = frame_of(sample_l, sample_r); ll = sample_l; lr = sample_r; acc_m = 1;
        end else begin
          frame_m = frame_of(ll, lr); und_m = 1;
        end
      end else if (sample_valid && !pend_m) begin
        pl = sample_l; pr = sample_r; pend_m = 1; acc_m = 1;
      end
    end
  end

  // Compare every output against the model once per clk, away from the active edge
  always @(negedge clk) begin
    int k, bc;
    logic exp_sd;
    k  = n / (2 * DIV);
    bc = k % 64;
    exp_sd = (k == 0) ? 1'b0 : frame_m[63 - ((bc + 63) % 64)];
    check("bclk", 64'(bclk), 64'((n / DIV) % 2));
    check("lrclk", 64'(lrclk), 64'(bc >= 32));
    check("sdata", 64'(sdata), 64'(exp_sd));
    check("underrun", 64'(underrun), 64'(und_m));
    check("sample_ready", 64'(sample_ready), 64'(!pend_m));
  end

  task automatic cycles(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic send(input logic [10:0] l, input logic [10:0] r);
    bit ok;
    ok = 0;
    sample_l = l; sample_r = r; sample_valid = 1'b1;
    for (int i = 0; i < 4 * FCLK && !ok; i++) begin
      @(negedge clk);
      if (acc_m) ok = 1;
    end
    sample_valid = 1'b0;
    check("send_accepted", 64'(ok), 64'd1);
  endtask

  task automatic wait_bitpos(input int b);
    bit ok;
    ok = 0;
    for (int i = 0; i < 2 * FCLK && !ok; i++) begin
      @(negedge clk);
      if (bitpos(n) == b && (n % (2 * DIV)) == 0) ok = 1;
    end
    check("wait_bitpos", 64'(ok), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bclk"}, 64'(bclk), 64'd0);
    check({tag, "_lrclk"}, 64'(lrclk), 64'd0);
    check({tag, "_sdata"}, 64'(sdata), 64'd0);
    check({tag, "_underrun"}, 64'(underrun), 64'd0);
    check({tag, "_ready"}, 64'(sample_ready), 64'd1);
  endtask

  initial begin
    int cnt;
    bit ok;

    // Reset and idle: midscale frames with one underrun per frame
    #1 rst_n = 1'b0;
    cycles(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    ena   = 1'b1;
    cycles(2 * FCLK);

    // Single full-scale pair
    send(11'h7FF, 11'h000);
    cycles(2 * FCLK);

    // Backpressure: keep valid high with incrementing pairs
    cnt = 0;
    sample_l = 11'd1; sample_r = 11'h7FE; sample_valid = 1'b1;
    for (int i = 0; i < 5 * FCLK; i++) begin
      @(negedge clk);
      if (acc_m) begin
        cnt++;
        sample_l = 11'(cnt + 1);
        sample_r = 11'(11'h7FE - cnt);
      end
    end
    sample_valid = 1'b0;
    check("bp_pairs_per_frame", 64'(cnt >= 5 && cnt <= 6), 64'd1);
    cycles(2 * FCLK);

    // Randomized traffic, data held until accepted
    for (int i = 0; i < 6 * FCLK; i++) begin
      @(negedge clk);
      if (!sample_valid || acc_m) begin
        sample_valid = ($urandom_range(0, 5) == 0);
        sample_l = 11'($urandom);
        sample_r = 11'($urandom);
      end
    end
    sample_valid = 1'b0;
    cycles(2 * FCLK);

    // Bypass: valid only on the load cycle with the holding register empty
    ok = 0;
    for (int i = 0; i < 2 * FCLK && !ok; i++) begin
      @(negedge clk);
      if (is_load(n + 1)) ok = 1;
    end
    check("bypass_found_load", 64'(ok), 64'd1);
    check("bypass_ready_before", 64'(sample_ready), 64'd1);
    sample_l = 11'($urandom); sample_r = 11'($urandom); sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    check("bypass_ready_after", 64'(sample_ready), 64'd1);
    check("bypass_no_underrun", 64'(underrun), 64'd0);
    cycles(FCLK);

    // Repeat last pair on underrun
    send(11'h600, 11'h600);
    cycles(3 * FCLK);

    // Asynchronous reset mid-frame with a pair pending
    wait_bitpos(18);
    send(11'h123, 11'h456);
    check("pend_before_rst", 64'(sample_ready), 64'd0);
    wait_bitpos(20);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    cycles(3);
    rst_n = 1'b1;
    cycles(2 * FCLK);

    // Synchronous ena drop with a pair pending
    wait_bitpos(18);
    send(11'h2AA, 11'h555);
    check("pend_before_ena", 64'(sample_ready), 64'd0);
    wait_bitpos(20);
    ena = 1'b0;
    @(negedge clk);
    check_reset_outputs("ena_low");
    cycles(2);
    ena = 1'b1;
    cycles(2 * FCLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
